// File: rtl/imm_pkg.sv
// Shared immediate-encoding definitions: ImmSrc enumeration, widths and fit predicates.
// Also consumed by the Extend unit so encoder and decoder agree on ImmSrc meaning.
package imm_pkg;

   localparam int VALUE_W = 32;
   localparam int INSTR_W = 20;

   typedef enum logic [1:0] {
      IMM_ZERO16     = 2'b00,
      IMM_SEXT16     = 2'b01,
      IMM_SEXT20_SH2 = 2'b10,
      IMM_AUTO       = 2'b11
   } imm_src_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      imm_src_e           immsrc;
      logic               fits;
   } imm_res_t;

   function automatic logic fits_zero16(input logic [VALUE_W-1:0] v);
      return (v[31:16] == 16'h0000);
   endfunction

   function automatic logic fits_sext16(input logic [VALUE_W-1:0] v);
      return (&v[31:15]) | ~(|v[31:15]);
   endfunction

   // Word-aligned and the upper bits replicate bit 21, the sign of the 20-bit field.
   function automatic logic fits_sext20_sh2(input logic [VALUE_W-1:0] v);
      return (v[1:0] == 2'b00) & ((&v[31:21]) | ~(|v[31:21]));
   endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational fit check and Instr[19:0] formation for one requested ImmSrc.
// Mode 11 resolves automatically only when IMM_ENCODE_AUTO_EN is defined.
module imm_fit_check
   import imm_pkg::*;
(
   input  logic [VALUE_W-1:0] value,
   input  logic [1:0]         mode,
   output imm_res_t           res
);

   logic               z_fit_s;
   logic               s16_fit_s;
   logic               s20_fit_s;
   logic [INSTR_W-1:0] instr16_s;
   logic [INSTR_W-1:0] instr20_s;

   assign z_fit_s   = fits_zero16(value);
   assign s16_fit_s = fits_sext16(value);
   assign s20_fit_s = fits_sext20_sh2(value);
   assign instr16_s = {4'b0000, value[15:0]};
   assign instr20_s = value[21:2];

   // Select the encoding for the requested mode.
   always_comb begin
      res = '0;
      case (mode)
         IMM_ZERO16:     res = '{instr: instr16_s, immsrc: IMM_ZERO16, fits: z_fit_s};
         IMM_SEXT16:     res = '{instr: instr16_s, immsrc: IMM_SEXT16, fits: s16_fit_s};
         IMM_SEXT20_SH2: res = '{instr: instr20_s, immsrc: IMM_SEXT20_SH2, fits: s20_fit_s};
         IMM_AUTO: begin
`ifdef IMM_ENCODE_AUTO_EN
            if (z_fit_s) begin
               res = '{instr: instr16_s, immsrc: IMM_ZERO16, fits: 1'b1};
            end else if (s16_fit_s) begin
               res = '{instr: instr16_s, immsrc: IMM_SEXT16, fits: 1'b1};
            end else begin
               res = '{instr: instr20_s, immsrc: IMM_SEXT20_SH2, fits: s20_fit_s};
            end
`else
            res = '{instr: {INSTR_W{1'b0}}, immsrc: IMM_AUTO, fits: 1'b0};
`endif
         end
         default:        res = '0;
      endcase
   end

endmodule

// File: rtl/imm_encode.sv
// Two-stage immediate encoder: S1 holds the classification, S2 is the output register.
// Optional feature macro: IMM_ENCODE_AUTO_EN (automatic ImmSrc selection for mode 11).
module imm_encode
   import imm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_value,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [19:0]        out_instr,
   output logic [1:0]         out_immsrc,
   output logic               out_fits,
   output logic [CNT_W-1:0]   err_count
);

   imm_res_t           fit_res_s;
   imm_res_t           s1_res_r;
   logic               s1_full_r;
   logic               out_valid_r;
   logic [19:0]        out_instr_r;
   logic [1:0]         out_immsrc_r;
   logic               out_fits_r;
   logic [CNT_W-1:0]   err_count_r;
   logic               ready_en_r;
   logic               s2_drain_s;
   logic               s1_adv_s;
   logic               in_ready_s;
   logic               in_fire_s;

   imm_fit_check u_fit (
      .value (in_value),
      .mode  (in_mode),
      .res   (fit_res_s)
   );

   assign s2_drain_s = out_valid_r & out_ready;
   assign s1_adv_s   = s1_full_r & (~out_valid_r | out_ready);
   // ready_en_r keeps in_ready low while reset is held, without a combinational path from rst_n.
   assign in_ready_s = ready_en_r & (~s1_full_r | s1_adv_s);
   assign in_fire_s  = in_valid & in_ready_s;

   // Input-enable flag and stage S1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_r <= 1'b0;
         s1_full_r  <= 1'b0;
         s1_res_r   <= '0;
      end else begin
         ready_en_r <= 1'b1;
         if (in_fire_s) begin
            s1_full_r <= 1'b1;
            s1_res_r  <= fit_res_s;
         end else if (s1_adv_s) begin
            s1_full_r <= 1'b0;
         end
      end
   end

   // Stage S2: the output register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         out_instr_r  <= 20'h00000;
         out_immsrc_r <= 2'b00;
         out_fits_r   <= 1'b0;
      end else if (s1_adv_s) begin
         out_valid_r  <= 1'b1;
         out_instr_r  <= s1_res_r.instr;
         out_immsrc_r <= s1_res_r.immsrc;
         out_fits_r   <= s1_res_r.fits;
      end else if (s2_drain_s) begin
         out_valid_r  <= 1'b0;
      end
   end

   // Saturating count of unrepresentable results handed to the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_r <= '0;
      end else if (s2_drain_s && !out_fits_r && (err_count_r != {CNT_W{1'b1}})) begin
         err_count_r <= err_count_r + CNT_W'(1);
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_r;
   assign out_instr  = out_instr_r;
   assign out_immsrc = out_immsrc_r;
   assign out_fits   = out_fits_r;
   assign err_count  = err_count_r;

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: arithmetic reference model, scoreboard and directed vectors.
module tb_imm_encode;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_value = 32'h0;
   logic [1:0]       in_mode = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [19:0]      out_instr;
   logic [1:0]       out_immsrc;
   logic             out_fits;
   logic [CNT_W-1:0] err_count;

   int          errors = 0;
   int          checks = 0;
   int          exp_err = 0;
   int          n_in = 0;
   int          n_out = 0;
   logic [22:0] exp_q[$];

   imm_encode #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_immsrc(out_immsrc), .out_fits(out_fits), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Reference: {fits, immsrc, instr} from numeric ranges of the value.
   function automatic logic [22:0] model(input logic [31:0] v, input logic [1:0] m);
      longint s;
      bit zf, s16, s20;
      logic [19:0] i16, i20;
      s   = longint'($signed(v));
      zf  = (v < 32'h0001_0000);
      s16 = (s >= -64'sd32768) && (s <= 64'sd32767);
      s20 = ((v % 32'd4) == 32'd0) && (s >= -64'sd2097152) && (s <= 64'sd2097151);
      i16 = 20'(v % 32'h0001_0000);
      i20 = 20'(v / 32'd4);
      case (m)
         2'b00: return {zf, 2'b00, i16};
         2'b01: return {s16, 2'b01, i16};
         2'b10: return {s20, 2'b10, i20};
         default: begin
`ifdef IMM_ENCODE_AUTO_EN
            if (zf) return {1'b1, 2'b00, i16};
            else if (s16) return {1'b1, 2'b01, i16};
            else return {s20, 2'b10, i20};
`else
            return {1'b0, 2'b11, 20'h00000};
`endif
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic        stall = 1'b0;
      logic [22:0] held = '0;
      logic [22:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_err = 0;
            stall = 1'b0;
         end else begin
            check("err_count", 32'(err_count), 32'(exp_err));
            if (stall) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_data", 32'({out_fits, out_immsrc, out_instr}), 32'(held));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got %h expected no output", {out_fits, out_immsrc, out_instr});
               end else begin
                  e = exp_q.pop_front();
                  check("out_result", 32'({out_fits, out_immsrc, out_instr}), 32'(e));
                  if (!e[22] && exp_err < 65535) exp_err++;
                  n_out++;
               end
            end
            stall = out_valid && !out_ready;
            held  = {out_fits, out_immsrc, out_instr};
            if (in_valid && in_ready) begin
               exp_q.push_back(model(in_value, in_mode));
               n_in++;
            end
         end
      end
   endtask

   task automatic send(input logic [31:0] v, input logic [1:0] m);
      bit got = 1'b0;
      in_valid = 1'b1;
      in_value = v;
      in_mode  = m;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no in_ready expected accept of %h", v);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   logic [31:0] vec_v[16] = '{32'h0000C3C3, 32'h0000C3C3, 32'hFFFFFFFF, 32'h00010F0C,
                              32'hFFFFE38C, 32'hFFFFE38C, 32'h00010001, 32'h00000005,
                              32'h12345678, 32'h00200000, 32'hFFE00000, 32'h00007FFF,
                              32'h00008000, 32'h00000006, 32'h0000FFFF, 32'h00010000};
   logic [1:0]  vec_m[16] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11,
                              2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
   logic [31:0] bp_v[4]   = '{32'h00000011, 32'hFFFF8000, 32'h00400000, 32'h00000024};
   logic [1:0]  bp_m[4]   = '{2'b00, 2'b01, 2'b10, 2'b10};

   initial begin
      int acc;
      int idx;
      bit take;
      fork
         monitor();
      join_none

      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", 32'(out_instr), 32'd0);
      check("rst_out_immsrc", 32'(out_immsrc), 32'd0);
      check("rst_out_fits", 32'(out_fits), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Hand-computed anchors for the reference model.
      check("model_c3c3_m00", 32'(model(32'h0000C3C3, 2'b00)), 32'({1'b1, 2'b00, 20'h0C3C3}));
      check("model_c3c3_m01", 32'(model(32'h0000C3C3, 2'b01)), 32'({1'b0, 2'b01, 20'h0C3C3}));
      check("model_ffff_m01", 32'(model(32'hFFFFFFFF, 2'b01)), 32'({1'b1, 2'b01, 20'h0FFFF}));
      check("model_10f0c_m10", 32'(model(32'h00010F0C, 2'b10)), 32'({1'b1, 2'b10, 20'h043C3}));
      check("model_e38c_m10", 32'(model(32'hFFFFE38C, 2'b10)), 32'({1'b1, 2'b10, 20'hFF8E3}));
      check("model_200000_m10", 32'(model(32'h00200000, 2'b10)), 32'({1'b0, 2'b10, 20'h80000}));
`ifdef IMM_ENCODE_AUTO_EN
      check("model_e38c_auto", 32'(model(32'hFFFFE38C, 2'b11)), 32'({1'b1, 2'b01, 20'h0E38C}));
      check("model_10001_auto", 32'(model(32'h00010001, 2'b11)), 32'({1'b0, 2'b10, 20'h04000}));
`else
      check("model_5_auto_off", 32'(model(32'h00000005, 2'b11)), 32'({1'b0, 2'b11, 20'h00000}));
`endif

      // Directed vectors at full throughput.
      for (int i = 0; i < 16; i++) send(vec_v[i], vec_m[i]);
      in_valid = 1'b0;
      drain();
      check("directed_count", 32'(n_out), 32'd16);

      // Backpressure: consumer stalls for 5 cycles while 4 inputs are offered.
      out_ready = 1'b0;
      acc = 0;
      idx = 0;
      in_valid = 1'b1;
      in_value = bp_v[0];
      in_mode  = bp_m[0];
      repeat (5) begin
         @(negedge clk);
         take = in_ready;
         @(posedge clk);
         #1;
         if (take) begin
            acc++;
            idx++;
            in_value = bp_v[idx % 4];
            in_mode  = bp_m[idx % 4];
         end
      end
      check("bp_accepted", 32'(acc), 32'd2);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      while (idx < 4) begin
         send(bp_v[idx], bp_m[idx]);
         idx++;
      end
      in_valid = 1'b0;
      drain();
      check("bp_in_out_balance", 32'(n_out), 32'(n_in));

      // Reset with two results in flight.
      out_ready = 1'b0;
      send(32'h00000001, 2'b01);
      send(32'h00010001, 2'b00);
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
      send(32'h00010001, 2'b11);
      in_valid = 1'b0;
      drain();
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating unrepresentable-value counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_value/in_mode are valid.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_value  input  32  target ExtImm value to encode.
REQ-007 SHALL have port in_mode  input  2  requested ImmSrc: 00 zero-ext16, 01 sign-ext16, 10 sign-ext20 shifted left by 2, 11 auto.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_instr  output  20  immediate field for Instr[19:0].
REQ-011 SHALL have port out_immsrc  output  2  ImmSrc the decoder must use.
REQ-012 SHALL have port out_fits  output  1  1 = value exactly representable; 0 = unrepresentable.
REQ-013 SHALL have port err_count  output  CNT_W  saturating count of out_fits=0 results transferred.

Function
REQ-014 SHALL treat mode 00 as fitting iff in_value[31:16]==0, giving instr = {4'b0, value[15:0]}.
REQ-015 SHALL treat mode 01 as fitting iff in_value[31:15] are all equal, giving instr = {4'b0, value[15:0]}.
REQ-016 SHALL treat mode 10 as fitting iff value[1:0]==0 and value[31:21] are all equal, giving instr = value[21:2].
REQ-017 SHALL, in auto mode, pick the first fitting mode in priority order 00, 01, 10; if none fits, report immsrc=10, instr=value[21:2], fits=0.
REQ-018 SHALL, for an explicit mode that does not fit, still output that mode and its instr truncation, with fits=0.
REQ-019 SHALL be a two-stage pipeline: S1 registers the classification, S2 is the output register; latency is 2 cycles from input handshake to out_valid when out_ready=1.
REQ-020 SHALL transfer on in_valid&in_ready and on out_valid&out_ready; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 SHALL advance S1 to S2 when S2 is empty or draining; in_ready = !S1_full | S1_advancing, so full throughput is one result per cycle.
REQ-022 SHALL, under full backpressure, hold two results and deassert in_ready without losing or duplicating data.
REQ-023 SHALL increment err_count on each output transfer with fits=0 and saturate at all-ones.

Reset
REQ-024 SHALL, while rst_n=0, clear both stages and drive out_valid=0, out_instr=0, out_immsrc=00, out_fits=0, err_count=0; in_ready SHALL be 0 during reset.
REQ-025 SHALL discard in-flight results when reset asserts mid-operation; after release, the first output SHALL come only from a new handshake.

Configuration
REQ-026 SHALL honour macro IMM_ENCODE_AUTO_EN: when defined, mode 11 behaves per REQ-017.
REQ-027 SHALL, when IMM_ENCODE_AUTO_EN is undefined, answer mode 11 with immsrc=11, instr=0, fits=0, counted as an error.

Structure
REQ-028 SHALL take the ImmSrc enumeration (IMM_ZERO16=00, IMM_SEXT16=01, IMM_SEXT20_SH2=10, IMM_AUTO=11) and the width constants (32, 20) from shared package imm_pkg, also used by Extend.
REQ-029 SHALL place the combinational fit check and instr formation in sub-module imm_fit_check, instantiated once ahead of S1.

Verification
REQ-030 SHALL cover: 0x0000C3C3 mode 00 -> instr 0x0C3C3, immsrc 00, fits 1; same value mode 01 -> fits 0.
REQ-031 SHALL cover: 0xFFFFFFFF mode 01 -> instr 0x0FFFF, fits 1; 0x00010F0C mode 10 -> instr 0x043C3, fits 1.
REQ-032 SHALL cover: 0xFFFFE38C auto -> immsrc 01, instr 0x0E38C; same value mode 10 -> instr 0xFF8E3, fits 1; 0x00010001 auto -> fits 0, err_count +1.
REQ-033 SHALL cover: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready drops after 2 are accepted; all 4 emerge in order, each exactly once.
REQ-034 SHALL cover: rst_n pulsed low with 2 results in flight -> out_valid=0 and err_count=0 immediately; no stale output after release.
REQ-035 SHALL cover: a build without IMM_ENCODE_AUTO_EN, input 0x00000005 mode 11 -> immsrc 11, instr 0, fits 0.
